// File: rtl/mem_wb.sv
// Memory-access stage with MEM/WB pipeline register.
// Runs loads/stores on a req/ack bus with a watchdog, formats load data, retires to WB.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   valid_i, pc_i, alu_out_i,
//   rs2_val_i, rd_i, funct3_i,
//   mem_read_i, mem_write_i,
//   mem_to_reg_i, reg_write_i    instruction from EX/MEM
//   stall_o                      upstream must hold inputs
//   dmem_*                       data-memory bus (req/ack)
//   wb_*                         MEM/WB register fields, wb_valid_o is a retire pulse
//   misaligned_o, bus_err_o      exception pulses aligned with wb_valid_o
module mem_wb #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] rs2_val_i,
  input  logic [4:0]  rd_i,
  input  logic [2:0]  funct3_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        mem_to_reg_i,
  input  logic        reg_write_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic        wb_valid_o,
  output logic [31:0] wb_pc_o,
  output logic [4:0]  wb_rd_o,
  output logic        wb_reg_write_o,
  output logic [31:0] wb_data_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // bus-side registers
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;

  // instruction context captured for the outstanding access
  logic [31:0] cap_pc_q, cap_pc_d;
  logic [4:0]  cap_rd_q, cap_rd_d;
  logic [2:0]  cap_f3_q, cap_f3_d;
  logic [1:0]  cap_off_q, cap_off_d;
  logic        cap_m2r_q, cap_m2r_d;
  logic        cap_rw_q, cap_rw_d;
  logic        cap_st_q, cap_st_d;

  // write-back register
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_pc_q, wb_pc_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_rw_q, wb_rw_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        mis_q, mis_d;
  logic        berr_q, berr_d;

  // decode of the incoming instruction
  logic        accept;
  logic        is_mem;
  logic        misaligned;
  logic        start;
  logic        ack_done;
  logic        abort;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] load_fmt;
  logic [31:0] cap_addr;

  always_comb begin
    accept     = valid_i && (state_q == IDLE);
    is_mem     = mem_read_i || mem_write_i;
    misaligned = 1'b0;
    unique case (1'b1)
      (funct3_i[1:0] == 2'b01): misaligned = alu_out_i[0];
      (funct3_i[1:0] == 2'b10): misaligned = |alu_out_i[1:0];
      default:                  misaligned = 1'b0;
    endcase
    start    = accept && is_mem && !misaligned;
    ack_done = (state_q == BUSY) && dmem_ack_i;
    // ack in the expiry cycle takes priority over the abort
    abort    = (state_q == BUSY) && !dmem_ack_i && (cnt_q == CNT_MAX);
  end

  // store lane steering; loads always read the full word
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = rs2_val_i;
    if (mem_write_i) begin
      unique case (1'b1)
        (funct3_i[1:0] == 2'b00): begin
          lane_be    = 4'b0001 << alu_out_i[1:0];
          lane_wdata = {4{rs2_val_i[7:0]}};
        end
        (funct3_i[1:0] == 2'b01): begin
          lane_be    = 4'b0011 << alu_out_i[1:0];
          lane_wdata = {2{rs2_val_i[15:0]}};
        end
        default: begin
          lane_be    = 4'b1111;
          lane_wdata = rs2_val_i;
        end
      endcase
    end
  end

  // load data formatting by captured size/sign and byte offset
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    unique case (cap_off_q)
      2'd0:    ld_byte = dmem_rdata_i[7:0];
      2'd1:    ld_byte = dmem_rdata_i[15:8];
      2'd2:    ld_byte = dmem_rdata_i[23:16];
      default: ld_byte = dmem_rdata_i[31:24];
    endcase
    ld_half = cap_off_q[1] ? dmem_rdata_i[31:16]
                           : dmem_rdata_i[15:0];
    load_fmt = dmem_rdata_i;
    unique case (1'b1)
      (cap_f3_q == 3'b000): load_fmt = {{24{ld_byte[7]}}, ld_byte};
      (cap_f3_q == 3'b001): load_fmt = {{16{ld_half[15]}}, ld_half};
      (cap_f3_q == 3'b100): load_fmt = {24'd0, ld_byte};
      (cap_f3_q == 3'b101): load_fmt = {16'd0, ld_half};
      default:              load_fmt = dmem_rdata_i;
    endcase
    cap_addr = {addr_q[31:2], cap_off_q};
  end

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state and watchdog counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (ack_done || abort) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: state-decoded outputs
  always_comb begin
    stall_o = (state_q == BUSY);
  end

  // datapath next values
  always_comb begin
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    cap_pc_d   = cap_pc_q;
    cap_rd_d   = cap_rd_q;
    cap_f3_d   = cap_f3_q;
    cap_off_d  = cap_off_q;
    cap_m2r_d  = cap_m2r_q;
    cap_rw_d   = cap_rw_q;
    cap_st_d   = cap_st_q;
    wb_valid_d = 1'b0;
    wb_pc_d    = wb_pc_q;
    wb_rd_d    = wb_rd_q;
    wb_rw_d    = wb_rw_q;
    wb_data_d  = wb_data_q;
    mis_d      = 1'b0;
    berr_d     = 1'b0;

    if (accept && !is_mem) begin
      wb_valid_d = 1'b1;
      wb_pc_d    = pc_i;
      wb_rd_d    = rd_i;
      wb_rw_d    = reg_write_i;
      wb_data_d  = alu_out_i;
    end

    if (accept && is_mem && misaligned) begin
      wb_valid_d = 1'b1;
      mis_d      = 1'b1;
      wb_pc_d    = pc_i;
      wb_rd_d    = rd_i;
      wb_rw_d    = 1'b0;
      wb_data_d  = alu_out_i;
    end

    if (start) begin
      req_d     = 1'b1;
      we_d      = mem_write_i;
      addr_d    = {alu_out_i[31:2], 2'b00};
      wdata_d   = lane_wdata;
      be_d      = lane_be;
      cap_pc_d  = pc_i;
      cap_rd_d  = rd_i;
      cap_f3_d  = funct3_i;
      cap_off_d = alu_out_i[1:0];
      cap_m2r_d = mem_to_reg_i;
      cap_rw_d  = reg_write_i;
      cap_st_d  = mem_write_i;
    end

    if (ack_done) begin
      req_d      = 1'b0;
      we_d       = 1'b0;
      wb_valid_d = 1'b1;
      wb_pc_d    = cap_pc_q;
      wb_rd_d    = cap_rd_q;
      if (cap_st_q) begin
        wb_rw_d   = 1'b0;
        wb_data_d = cap_addr;
      end else begin
        wb_rw_d   = cap_rw_q;
        wb_data_d = cap_m2r_q ? load_fmt : cap_addr;
      end
    end

    if (abort) begin
      req_d      = 1'b0;
      we_d       = 1'b0;
      wb_valid_d = 1'b1;
      berr_d     = 1'b1;
      wb_pc_d    = cap_pc_q;
      wb_rd_d    = cap_rd_q;
      wb_rw_d    = 1'b0;
      wb_data_d  = cap_addr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      cap_pc_q   <= '0;
      cap_rd_q   <= '0;
      cap_f3_q   <= '0;
      cap_off_q  <= '0;
      cap_m2r_q  <= 1'b0;
      cap_rw_q   <= 1'b0;
      cap_st_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_pc_q    <= '0;
      wb_rd_q    <= '0;
      wb_rw_q    <= 1'b0;
      wb_data_q  <= '0;
      mis_q      <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      cap_pc_q   <= cap_pc_d;
      cap_rd_q   <= cap_rd_d;
      cap_f3_q   <= cap_f3_d;
      cap_off_q  <= cap_off_d;
      cap_m2r_q  <= cap_m2r_d;
      cap_rw_q   <= cap_rw_d;
      cap_st_q   <= cap_st_d;
      wb_valid_q <= wb_valid_d;
      wb_pc_q    <= wb_pc_d;
      wb_rd_q    <= wb_rd_d;
      wb_rw_q    <= wb_rw_d;
      wb_data_q  <= wb_data_d;
      mis_q      <= mis_d;
      berr_q     <= berr_d;
    end
  end

  assign dmem_req_o     = req_q;
  assign dmem_we_o      = we_q;
  assign dmem_addr_o    = addr_q;
  assign dmem_wdata_o   = wdata_q;
  assign dmem_be_o      = be_q;
  assign wb_valid_o     = wb_valid_q;
  assign wb_pc_o        = wb_pc_q;
  assign wb_rd_o        = wb_rd_q;
  assign wb_reg_write_o = wb_rw_q;
  assign wb_data_o      = wb_data_q;
  assign misaligned_o   = mis_q;
  assign bus_err_o      = berr_q;

endmodule
